// File: rtl/mem_stage.sv
// Memory-access stage: registers the execute bus, extracts/extends load data and holds SRAM
// read data across stalls. Define MEM_ADDR_CHK_EN to add the misaligned-load flag mem_adel.
`ifndef StallBus
`define StallBus 6
`endif

module mem_stage #(
    parameter int IN_WD  = 79,
    parameter int OUT_WD = 70,
    parameter int FWD_WD = 38
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`StallBus-1:0] stall,
    input  logic [IN_WD-1:0]     ex_to_mem_bus,
    input  logic [31:0]          data_sram_rdata,
    output logic [OUT_WD-1:0]    mem_to_wb_bus,
    output logic [FWD_WD-1:0]    mem_to_rf_bus
`ifdef MEM_ADDR_CHK_EN
    ,
    output logic                 mem_adel
`endif
);

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100
    } mem_op_e;

    logic [IN_WD-1:0] bus_r;
    logic [31:0]      rdata_buf;
    logic             buf_vld;

    logic [31:0] pc;
    logic [2:0]  mem_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [1:0]  off;
    logic        is_load;

    assign pc           = bus_r[78:47];
    assign mem_op       = bus_r[46:44];
    assign data_ram_en  = bus_r[43];
    assign data_ram_wen = bus_r[42:39];
    assign sel_rf_res   = bus_r[38];
    assign rf_we        = bus_r[37];
    assign rf_waddr     = bus_r[36:32];
    assign ex_result    = bus_r[31:0];
    assign off          = ex_result[1:0];
    assign is_load      = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;

    // Any bus_r update (new instruction or bubble) retires the buffered data with it;
    // the buffer only captures on the first stalled cycle of a load.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r     <= '0;
            rdata_buf <= '0;
            buf_vld   <= 1'b0;
        end else if (stall[3] && !stall[4]) begin
            bus_r   <= '0;
            buf_vld <= 1'b0;
        end else if (!stall[3]) begin
            bus_r   <= ex_to_mem_bus;
            buf_vld <= 1'b0;
        end else if (is_load && !buf_vld && stall[4]) begin
            rdata_buf <= data_sram_rdata;
            buf_vld   <= 1'b1;
        end
    end

    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;
    logic [31:0] mem_result;
    logic        rf_we_eff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        raw       = buf_vld ? rdata_buf : data_sram_rdata;
        byte_sel  = raw[{off, 3'b000} +: 8];
        half_sel  = off[1] ? raw[31:16] : raw[15:0];
        extracted = raw;
        case (mem_op_e'(mem_op))
            OP_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  extracted = {24'b0, byte_sel};
            OP_LH:   extracted = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  extracted = {16'b0, half_sel};
            default: extracted = raw;
        endcase
        mem_result = is_load ? extracted : ex_result;
    end

`ifdef MEM_ADDR_CHK_EN
    logic half_op;
    logic word_op;

    assign half_op   = (mem_op == OP_LH) || (mem_op == OP_LHU);
    assign word_op   = (mem_op == OP_LW) || (mem_op > OP_LHU);
    assign mem_adel  = is_load & ((half_op & off[0]) | (word_op & (off != 2'b00)));
    assign rf_we_eff = rf_we & ~mem_adel;
`else
    assign rf_we_eff = rf_we;
`endif

    assign mem_to_wb_bus = {pc, rf_we_eff, rf_waddr, mem_result};
    assign mem_to_rf_bus = {rf_we_eff, rf_waddr, mem_result};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the execute stage.
- Registers the execute-to-memory bus under stall control and receives synchronous data-SRAM read data one cycle after the execute stage issues the request.
- Extracts and extends the load byte, halfword or word; selects load data or ALU result.
- Drives the memory-to-writeback bus and a forwarding bus back to the register-file/decode stage.
- Holds SRAM read data across pipeline stalls so it is never lost.

Parameters:
- IN_WD, 79, width of ex_to_mem_bus.
- OUT_WD, 70, width of mem_to_wb_bus.
- FWD_WD, 38, width of mem_to_rf_bus.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  `StallBus  pipeline stall vector; bit 3 = execute-side hold, bit 4 = memory-side hold.
- ex_to_mem_bus  in  IN_WD  {pc[78:47], mem_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rdata  in  32  synchronous SRAM read data, valid the cycle after the request.
- mem_to_wb_bus  out  OUT_WD  {pc[69:38], rf_we[37], rf_waddr[36:32], mem_result[31:0]}.
- mem_to_rf_bus  out  FWD_WD  {rf_we[37], rf_waddr[36:32], mem_result[31:0]}; forwarding path, same content as mem_to_wb_bus without pc.

Behaviour:
- Stage register bus_r, evaluated in this priority:
  - rst: bus_r=0.
  - stall[3]=Stop and stall[4]=NoStop: bus_r=0 (bubble).
  - stall[3]=NoStop: bus_r=ex_to_mem_bus.
  - Otherwise: hold.
- Reset values: bus_r=0, rdata_buf=0, buf_vld=0. Hence both outputs are all-zero out of reset and rf_we=0.
- Load condition: is_load = data_ram_en & (data_ram_wen==0) & sel_rf_res. Stores have data_ram_wen!=0 and never write the register file through this path.
- Read-data hold buffer:
  - Set: when is_load, buf_vld=0 and stall[4]=Stop, capture data_sram_rdata into rdata_buf and set buf_vld=1.
  - Clear: buf_vld clears on any bus_r update (load or bubble) and on rst.
  - Data source: raw = buf_vld ? rdata_buf : data_sram_rdata.
  - Multi-cycle stalls must not recapture.
- Extraction uses off = ex_result[1:0] (byte address).
  - mem_op 000 LW: raw.
  - 001 LB: sign-extend raw[8*off+7 : 8*off].
  - 010 LBU: zero-extend the same byte.
  - 011 LH: sign-extend raw[16*off[1]+15 : 16*off[1]].
  - 100 LHU: zero-extend the same halfword.
  - 101–111: treated as LW.
- Result select: mem_result = is_load ? extracted : ex_result. The path is combinational from bus_r and the buffer; the output is registered by the next stage.
- Latency: one cycle from bus_r capture to outputs; load data appears in the same cycle as the SRAM returns it.
- A bubble or reset mid-stall discards the buffer; no stale data reaches a later instruction.

Optional Feature:
- Macro: MEM_ADDR_CHK_EN.
- With the macro defined:
  - Adds output mem_adel (1 bit) = is_load & ((mem_op in {011,100} & off[0]) | (mem_op in {000,101,110,111} & off!=0)).
  - While mem_adel=1, rf_we is forced to 0 on both output buses; mem_result is unchanged.
  - Reset value of mem_adel is 0.
- Without the macro: no port and no check; misaligned accesses use the off-based extraction as defined.

Test Plan:
- Reset, then deassert → mem_to_wb_bus=0, mem_to_rf_bus=0; one cycle later with ALU op pc=0xBFC00000, rf_we=1, waddr=5, result=0x1234 → wb bus carries those values, mem_result=0x1234.
- LB at ex_result=0x...02, rdata=0x80FF7F00 → mem_result=0xFFFFFFFF; LBU → 0x000000FF; LH at off=2 → 0xFFFF80FF; LHU → 0x000080FF.
- LW with rdata=0xDEADBEEF, stall[4]=Stop for 3 cycles while rdata changes to 0x0 → mem_result stays 0xDEADBEEF every cycle; after release the next instruction sees buf_vld=0.
- stall[3]=Stop, stall[4]=NoStop → bus_r becomes 0, rf_we=0 next cycle; stall[3]=stall[4]=Stop → bus_r held.
- Assert rst during a buffered load stall → next cycle outputs 0 and buf_vld=0.
- With MEM_ADDR_CHK_EN: LH at off=1 → mem_adel=1, rf_we=0; LW at off=0 → mem_adel=0, rf_we=1.
